// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_responder
//  Purpose  : Word-addressed data memory for the MEM stage. A request is
//             latched in IDLE, held for LATENCY wait cycles and completed with
//             a one-cycle done pulse. busy stalls the pipeline meanwhile.
//  Option   : define DMEM_ALIGN_CHECK_EN to fault misaligned accesses
//             (no storage access, immediate DONE, addrError pulse).
//  Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memRead,
   input  logic        memWrite,
   input  logic [31:0] address,
   input  logic [31:0] writeData,
   output logic [31:0] readData,
   output logic        busy,
   output logic        done,
   output logic        addrError
);

   localparam int         AW         = $clog2(DEPTH_WORDS);
   localparam logic [3:0] c_LAT      = 4'(LATENCY);
   localparam logic       c_ZERO_LAT = (LATENCY == 0);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    r_state;
   logic [1:0]    w_next;
   logic [3:0]    r_cnt;
   logic [AW-1:0] r_idx;
   logic [31:0]   r_wdata;
   logic          r_is_wr;
   logic          r_fault;
   logic [31:0]   r_mem [DEPTH_WORDS];

   logic          w_req;
   logic          w_accept;
   logic          w_in_fault;
   logic          w_fin_wait;
   logic          w_commit;
   logic          w_op_wr;
   logic [AW-1:0] w_op_idx;
   logic [31:0]   w_op_data;
   logic          w_unused_addr;

   assign w_req    = memRead | memWrite;
   assign w_accept = (r_state == S_IDLE) & w_req & ~reset;

`ifdef DMEM_ALIGN_CHECK_EN
   assign w_in_fault = (address[1:0] != 2'b00);
`else
   assign w_in_fault = 1'b0;
`endif

   // Byte-lane bits and bits above the storage window never select a word.
   assign w_unused_addr = ^{address[31:AW+2], address[1:0]};

   // Storage is touched on the edge that enters DONE. With zero latency that
   // edge is the accept edge itself, so the live inputs stand in for the
   // latched copy; otherwise only the latched transaction is used.
   assign w_fin_wait = (r_state == S_WAIT) && (r_cnt <= 4'd1);
   assign w_commit   = (w_fin_wait & ~r_fault) |
                       (w_accept & c_ZERO_LAT & ~w_in_fault);
   assign w_op_wr    = (r_state == S_IDLE) ? memWrite           : r_is_wr;
   assign w_op_idx   = (r_state == S_IDLE) ? address[AW+1:2]    : r_idx;
   assign w_op_data  = (r_state == S_IDLE) ? writeData          : r_wdata;

   // State register, cleared asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state logic: a faulted or zero-latency request skips WAIT.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_req) w_next = (w_in_fault || c_ZERO_LAT) ? S_DONE : S_WAIT;
         S_WAIT: if (r_cnt <= 4'd1) w_next = S_DONE;
         S_DONE: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Outputs: done/addrError follow the DONE state, busy stalls the pipeline.
   always_comb begin
      busy = ~reset & ((r_state == S_WAIT) | ((r_state == S_IDLE) & w_req));
      done = (r_state == S_DONE);
`ifdef DMEM_ALIGN_CHECK_EN
      addrError = (r_state == S_DONE) & r_fault;
`else
      addrError = 1'b0;
`endif
   end

   // Transaction latch and wait counter; a request is captured on accept.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt   <= 4'd0;
         r_idx   <= '0;
         r_wdata <= 32'd0;
         r_is_wr <= 1'b0;
         r_fault <= 1'b0;
      end else if (w_accept) begin
         r_cnt   <= c_LAT;
         r_idx   <= address[AW+1:2];
         r_wdata <= writeData;
         r_is_wr <= memWrite;
         r_fault <= w_in_fault;
      end else if (r_state == S_WAIT) begin
         r_cnt   <= r_cnt - 4'd1;
      end
   end

   // Load data register; only a completed, non-faulted read updates it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                    readData <= 32'd0;
      else if (w_commit && !w_op_wr) readData <= r_mem[w_op_idx];
   end

   // Storage array; never cleared, and reset suppresses a pending commit.
   always_ff @(posedge clk) begin
      if (!reset && w_commit && w_op_wr) r_mem[w_op_idx] <= w_op_data;
   end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_responder
//  Purpose  : Directed plus randomized bench for data_mem_responder with a
//             transaction-level memory model (DEPTH_WORDS=256, LATENCY=2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

   localparam int DEPTH = 256;
   localparam int LAT   = 2;
   localparam int AW    = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        memRead = 1'b0;
   logic        memWrite = 1'b0;
   logic [31:0] address = 32'd0;
   logic [31:0] writeData = 32'd0;
   logic [31:0] readData;
   logic        busy;
   logic        done;
   logic        addrError;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] mem_m [DEPTH];
   logic [31:0] exp_rdata = 32'd0;

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clk       (clk),
      .reset     (reset),
      .memRead   (memRead),
      .memWrite  (memWrite),
      .address   (address),
      .writeData (writeData),
      .readData  (readData),
      .busy      (busy),
      .done      (done),
      .addrError (addrError)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete transaction, checked cycle by cycle against the model.
   task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input bit scramble);
      bit fault;
      int lat;
      int idx;
      fault = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
      fault = (addr[1:0] != 2'b00);
`endif
      lat = fault ? 1 : LAT + 1;
      idx = int'(addr[AW+1:2]);
      memRead = rd; memWrite = wr; address = addr; writeData = data;
      #1;
      chk("idle_busy", busy, 32'd1);
      chk("idle_done", done, 32'd0);
      tick();
      if (!fault) begin
         if (wr)      mem_m[idx] = data;
         else if (rd) exp_rdata = mem_m[idx];
      end
      for (int c = 1; c <= lat; c++) begin
         if (scramble) begin
            memRead = 1'($urandom); memWrite = 1'($urandom);
            address = $urandom;     writeData = $urandom;
         end else begin
            memRead = 1'b0; memWrite = 1'b0;
         end
         #1;
         if (c < lat) begin
            chk("wait_done", done, 32'd0);
            chk("wait_busy", busy, 32'd1);
         end else begin
            chk("done_pulse", done, 32'd1);
            chk("done_busy", busy, 32'd0);
            chk("done_addrerr", addrError, {31'd0, fault});
            chk("done_rdata", readData, exp_rdata);
         end
         memRead = 1'b0; memWrite = 1'b0;
         tick();
      end
      chk("after_done", done, 32'd0);
   endtask

   initial begin
      logic [31:0] a;
      logic [1:0]  op;
      bit          d_exp [8];
      bit          b_exp [8];

      // Asynchronous reset before any clock edge; a request is present.
      memRead = 1'b1;
      #1 reset = 1'b1;
      #2;
      chk("rst_rdata", readData, 32'd0);
      chk("rst_done", done, 32'd0);
      chk("rst_busy", busy, 32'd0);
      chk("rst_addrerr", addrError, 32'd0);
      tick();
      tick();
      chk("rst_busy_edge", busy, 32'd0);
      memRead = 1'b0;
      reset = 1'b0;
      tick();

      // Fill every word so later reads have defined contents.
      for (int i = 0; i < DEPTH; i++) access(1'b0, 1'b1, 32'(i * 4), $urandom, 1'b0);

      // Write timing, read-back, and readData holding across a write.
      access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
      access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
      chk("read_deadbeef", readData, 32'hDEADBEEF);
      access(1'b0, 1'b1, 32'h44, 32'h01020304, 1'b0);
      chk("hold_after_write", readData, 32'hDEADBEEF);

      // Address wrap modulo the storage size.
      access(1'b0, 1'b1, 32'h400, 32'h12345678, 1'b0);
      access(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      chk("wrap_read", readData, 32'h12345678);

      // Both strobes high acts as a write and leaves readData alone.
      access(1'b1, 1'b1, 32'h18, 32'h5A5A5A5A, 1'b0);
      access(1'b1, 1'b0, 32'h18, 32'h0, 1'b0);
      chk("both_is_write", readData, 32'h5A5A5A5A);

      // Reset during WAIT drops the write; storage keeps the old word.
      memWrite = 1'b1; address = 32'h20; writeData = 32'hCAFEF00D;
      tick();
      memWrite = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("midrst_rdata", readData, 32'd0);
      chk("midrst_done", done, 32'd0);
      chk("midrst_busy", busy, 32'd0);
      memRead = 1'b1;
      tick();
      chk("midrst_noaccept", busy, 32'd0);
      memRead = 1'b0;
      reset = 1'b0;
      exp_rdata = 32'd0;
      for (int c = 0; c < 5; c++) begin
         chk("midrst_nodone", done, 32'd0);
         tick();
      end
      access(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
      chk("midrst_prior", readData, mem_m[8]);

      // memRead held over two back-to-back reads; inputs change during WAIT.
      d_exp = '{0, 0, 0, 1, 0, 0, 0, 1};
      b_exp = '{1, 1, 1, 0, 1, 1, 1, 0};
      memRead = 1'b1; address = 32'h4;
      #1;
      chk("b2b_c0_busy", busy, 32'd1);
      tick();
      address = 32'h8;
      for (int c = 1; c < 8; c++) begin
         #1;
         chk("b2b_done", done, {31'd0, d_exp[c]});
         chk("b2b_busy", busy, {31'd0, b_exp[c]});
         if (c == 3) chk("b2b_rd0", readData, mem_m[1]);
         if (c == 7) begin
            chk("b2b_rd1", readData, mem_m[2]);
            memRead = 1'b0;
         end
         tick();
      end
      exp_rdata = mem_m[2];

      // Misaligned store; outcome depends on the alignment-check build.
      access(1'b0, 1'b1, 32'h13, 32'hA5A50013, 1'b0);
      access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);

      // Randomized traffic with garbage inputs during WAIT/DONE.
      for (int k = 0; k < 300; k++) begin
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
`ifdef DMEM_ALIGN_CHECK_EN
         if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
`endif
         access(op == 2'd0 || op == 2'd2 || op == 2'd3, op == 2'd1 || op == 2'd2,
                a, $urandom, 1'($urandom));
         for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning word count of storage (power of two, 16..4096).
REQ-002 SHALL have parameter LATENCY, default 2, meaning wait cycles inserted per access (0..15).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port memRead  input  1  read request from the MEM stage.
REQ-006 SHALL have port memWrite  input  1  write request from the MEM stage.
REQ-007 SHALL have port address  input  32  byte address.
REQ-008 SHALL have port writeData  input  32  store data.
REQ-009 SHALL have port readData  output  32  load data, registered.
REQ-010 SHALL have port busy  output  1  stall request to the pipeline.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port addrError  output  1  misaligned-access flag.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-014 SHALL, in IDLE with memRead or memWrite high at a clk edge (accept edge), latch address, writeData and operation, load counter with LATENCY, and go to WAIT (or DONE directly if LATENCY=0).
REQ-015 SHALL, in WAIT, decrement the counter each edge and go to DONE on the edge where counter is 1.
REQ-016 SHALL assert done exactly LATENCY+1 cycles after the accept edge, for one cycle, then return to IDLE.
REQ-017 SHALL drive busy combinationally: 1 in WAIT, 1 in IDLE while memRead or memWrite is high, 0 in DONE.
REQ-018 SHALL never accept a new request in DONE; a request held in DONE is accepted only from the following IDLE cycle.
REQ-019 SHALL treat memRead and memWrite both high as a write; readData unchanged.
REQ-020 SHALL commit a write and load readData for a read on the edge entering DONE, using latched values only.
REQ-021 SHALL hold readData until the next completed read.
REQ-022 SHALL index storage with address[log2(DEPTH_WORDS)+1:2]; higher bits ignored (addresses wrap modulo DEPTH_WORDS*4).
REQ-023 SHALL ignore input changes or request deassertion during WAIT; the latched transaction completes.

Reset
REQ-024 SHALL, on reset asserted, immediately force IDLE, counter 0, readData 0, done 0, addrError 0 regardless of clk.
REQ-025 SHALL drop an in-flight write on reset mid-operation; storage contents SHALL NOT be cleared.
REQ-026 SHALL accept no request while reset is high; busy 0 during reset.

Configuration
REQ-027 SHALL provide macro DMEM_ALIGN_CHECK_EN.
REQ-028 SHALL, with DMEM_ALIGN_CHECK_EN defined, treat an accepted request with address[1:0] != 0 as faulted: no storage access, go to DONE on the next edge (LATENCY bypassed), addrError=1 in that DONE cycle only, readData unchanged.
REQ-029 SHALL, without DMEM_ALIGN_CHECK_EN, ignore address[1:0] and tie addrError to 0.

Verification
REQ-030 SHALL verify (LATENCY=2): write 0xDEADBEEF to 0x10 accepted at cycle 0 -> busy 1 cycles 0-2, done=1 at cycle 3 only, busy 0 at cycle 3.
REQ-031 SHALL verify: read 0x10 after REQ-030 -> readData=0xDEADBEEF when done=1; readData holds through a following write.
REQ-032 SHALL verify wrap: write 0x12345678 to 0x400 (DEPTH 256) then read 0x0 -> 0x12345678.
REQ-033 SHALL verify: reset pulse during WAIT of write 0xCAFEF00D to 0x20 -> IDLE, readData=0, done never pulses; subsequent read of 0x20 returns the prior value.
REQ-034 SHALL verify: memRead held continuously over two back-to-back accesses (0x4, 0x8) -> two done pulses 4 cycles apart, one IDLE cycle between them.
REQ-035 SHALL verify with DMEM_ALIGN_CHECK_EN: write to 0x13 -> done and addrError=1 one cycle after accept, storage at 0x10 unchanged; without the macro, same access writes word 0x10, addrError=0.
